data_memory_ctrl: RTL and testbench

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

---
 rtl/data_memory_ctrl_pkg.sv | 13 +
 rtl/dm_ram_bytewise.sv | 32 +++
 rtl/data_memory_ctrl.sv | 133 +++++++++++++
 tb/tb_data_memory_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_ctrl_pkg.sv
// Shared constants and FSM encoding for the data memory controller.
package data_memory_ctrl_pkg;

    localparam int unsigned DefDataW = 16;
    localparam int unsigned DefAddrW = 16;
    localparam int unsigned DefDepth = 1024;

    typedef enum logic {
        StIdle  = 1'b0,
        StClear = 1'b1
    } state_e;

endpackage

// File: rtl/dm_ram_bytewise.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module dm_ram_bytewise #(
    parameter int unsigned DataW = 16,
    parameter int unsigned Depth = 1024,
    parameter int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic               clk_i,
    input  logic               en_i,
    input  logic               we_i,
    input  logic [AddrW-1:0]   addr_i,
    input  logic [DataW/8-1:0] be_i,
    input  logic [DataW-1:0]   wdata_i,
    output logic [DataW-1:0]   rdata_o
);

    logic [DataW-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < DataW / 8; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                    end
                end
            end else begin
                rdata_o <= mem_q[addr_i];
            end
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Request/response controller around dm_ram_bytewise: range check, 1-cycle reads,
// byte-masked writes and a zero-fill sweep FSM.
module data_memory_ctrl
    import data_memory_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W        = DefDataW,
    parameter int unsigned ADDR_W        = DefAddrW,
    parameter int unsigned DEPTH         = DefDepth,
    parameter int unsigned INIT_ON_RESET = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic                err,
    input  logic                clr_start,
    output logic                busy
);

    localparam int unsigned     RamAw   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DepthW  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LastIdx = (ADDR_W + 1)'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                init_q;
    logic                accept, in_range;
    logic                rd_valid_q, err_q, oor_q;
    logic [DATA_W-1:0]   rd_hold_q;

    logic                ram_en, ram_we;
    logic [RamAw-1:0]    ram_addr;
    logic [DATA_W/8-1:0] ram_be;
    logic [DATA_W-1:0]   ram_wdata, ram_rdata;

    // Compare one bit wider than the address so DEPTH == 2**ADDR_W still works.
    assign in_range = {1'b0, req_addr} < DepthW;
    assign accept   = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            init_q  <= (INIT_ON_RESET != 0);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            init_q  <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (clr_start || init_q) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                if (cnt_q == LastIdx) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q == StClear);
        req_ready = (state_q == StIdle) && !clr_start && !init_q;
        if (busy) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = cnt_q[RamAw-1:0];
            ram_be    = '1;
            ram_wdata = '0;
        end else begin
            ram_en    = accept && in_range;
            ram_we    = req_we;
            ram_addr  = req_addr[RamAw-1:0];
            ram_be    = req_be;
            ram_wdata = req_wdata;
        end
    end

    dm_ram_bytewise #(
        .DataW (DATA_W),
        .Depth (DEPTH),
        .AddrW (RamAw)
    ) u_ram (
        .clk_i   (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .be_i    (ram_be),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            oor_q      <= 1'b0;
            rd_hold_q  <= '0;
        end else begin
            rd_valid_q <= accept && !req_we;
            err_q      <= accept && !in_range;
            oor_q      <= !in_range;
            if (rd_valid_q) begin
                rd_hold_q <= rd_data;
            end
        end
    end

    // RAM output is already registered; the hold register keeps it stable between reads.
    assign rd_valid = rd_valid_q;
    assign err      = err_q;
    assign rd_data  = rd_valid_q ? (oor_q ? '0 : ram_rdata) : rd_hold_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: reference memory model, random and directed traffic.
module tb_data_memory_ctrl;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          req_valid, req_ready, req_we, rd_valid, err, clr_start, busy;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata, rd_data;
    logic [1:0]    req_be;

    logic          r2_ready, r2_valid, r2_err, busy2;
    logic [DW-1:0] r2_data;
    logic [3:0]    zero_addr4 = '0;
    logic [DW-1:0] zero_data = '0;
    logic [1:0]    zero_be = '0;
    logic          zero_bit = 1'b0;

    data_memory_ctrl #(
        .DATA_W (DW), .ADDR_W (AW), .DEPTH (DEPTH), .INIT_ON_RESET (0)
    ) dut (
        .clk (clk), .rst (rst), .req_valid (req_valid), .req_ready (req_ready),
        .req_we (req_we), .req_addr (req_addr), .req_wdata (req_wdata), .req_be (req_be),
        .rd_valid (rd_valid), .rd_data (rd_data), .err (err), .clr_start (clr_start),
        .busy (busy)
    );

    // Full-depth (DEPTH == 2**ADDR_W) instance with sweep on reset release.
    data_memory_ctrl #(
        .DATA_W (DW), .ADDR_W (4), .DEPTH (16), .INIT_ON_RESET (1)
    ) dut2 (
        .clk (clk), .rst (rst), .req_valid (zero_bit), .req_ready (r2_ready),
        .req_we (zero_bit), .req_addr (zero_addr4), .req_wdata (zero_data), .req_be (zero_be),
        .rd_valid (r2_valid), .rd_data (r2_data), .err (r2_err), .clr_start (zero_bit),
        .busy (busy2)
    );

    typedef struct {
        logic        is_rd;
        logic [15:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [15:0] model [DEPTH];
    logic [15:0] last_exp = '0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per presented output.
    always @(negedge clk) begin
        if (rst) begin
            last_exp = '0;
        end else if (rd_valid || err) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got rd_valid=%0b err=%0b expected none",
                         rd_valid, err);
            end else begin
                mon_e = q.pop_front();
                chk("out_cycle", cyc, mon_e.cyc);
                chk("rd_valid", {31'd0, rd_valid}, {31'd0, mon_e.is_rd});
                chk("err", {31'd0, err}, {31'd0, mon_e.err});
                if (mon_e.is_rd) begin
                    chk("rd_data", {16'd0, rd_data}, {16'd0, mon_e.data});
                    last_exp = mon_e.data;
                end
            end
        end
        if (!rst && !rd_valid) chk("rd_data_hold", {16'd0, rd_data}, {16'd0, last_exp});
    end

    task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                          input logic [1:0] be);
        exp_t        e;
        logic [15:0] m;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        #1;
        if (req_ready) begin
            e.cyc   = cyc + 1;
            e.is_rd = !we;
            e.err   = (addr >= DEPTH);
            e.data  = '0;
            if (!we) begin
                if (addr < DEPTH) e.data = model[addr[9:0]];
                q.push_back(e);
            end else if (addr >= DEPTH) begin
                q.push_back(e);
            end else begin
                m = {{8{be[1]}}, {8{be[0]}}};
                model[addr[9:0]] = (model[addr[9:0]] & ~m) | (wd & m);
            end
        end else begin
            checks++;
            failures++;
            $display("FAIL req_ready: got 0 expected 1 (addr 0x%0h)", addr);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid = 1'b0;
            clr_start = 1'b0;
        end
    endtask

    initial begin
        int cnt;
        int nrdy;
        logic [15:0] a;
        req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; req_be = '0; clr_start = 0;
        repeat (3) @(negedge clk);
        chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_rd_data", {16'd0, rd_data}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_busy2", {31'd0, busy2}, 32'd0);
        rst = 1'b0;
        #1 chk("init_busy_before_edge", {31'd0, busy2}, 32'd0);
        cnt = 0;
        repeat (24) begin
            @(negedge clk);
            if (busy2) cnt++;
        end
        chk("init_sweep_len", cnt, 16);

        // Clear sweep with a competing request.
        @(negedge clk);
        clr_start = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 16'd7;
        #1 chk("ready_on_clr_start", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        clr_start = 1'b0;
        cnt = 0; nrdy = 0;
        while (busy && cnt < 2000) begin
            cnt++;
            if (req_ready) nrdy++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("clear_len", cnt, 1024);
        chk("ready_in_clear", nrdy, 0);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        do_req(0, 16'd7, '0, 2'b00);

        do_req(1, 16'd2, 16'h3333, 2'b11);
        do_req(0, 16'd2, '0, 2'b00);
        do_req(1, 16'd5, 16'hAAAA, 2'b11);
        do_req(1, 16'd5, 16'h1255, 2'b01);
        do_req(0, 16'd5, '0, 2'b00);

        do_req(0, 16'd1024, '0, 2'b00);
        do_req(1, 16'd1024, 16'hFFFF, 2'b11);
        do_req(1, 16'hFFFF, 16'hBEEF, 2'b11);
        do_req(0, 16'd0, '0, 2'b00);
        do_req(0, 16'hFFFF, '0, 2'b00);

        for (int i = 0; i < 3; i++) do_req(1, 16'(i), 16'($urandom), 2'b11);
        for (int i = 0; i < 3; i++) do_req(0, 16'(i), '0, 2'b00);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                idle(1);
            end else begin
                if ($urandom_range(0, 15) == 0) a = 16'($urandom_range(1024, 65535));
                else if ($urandom_range(0, 1) == 0) a = 16'($urandom_range(0, 31));
                else a = 16'($urandom_range(0, 1023));
                do_req(1'($urandom_range(0, 1)), a, 16'($urandom), 2'($urandom));
            end
        end

        // Reset in the middle of a sweep.
        for (int i = 0; i < 12; i++) do_req(1, 16'(i), 16'h8001 | 16'($urandom), 2'b11);
        do_req(1, 16'd500, 16'h4001 | 16'($urandom), 2'b11);
        idle(3);
        @(negedge clk);
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("midreset_err", {31'd0, err}, 32'd0);
        chk("midreset_rd_data", {16'd0, rd_data}, 32'd0);
        for (int i = 0; i < 10; i++) model[i] = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) do_req(0, 16'(i), '0, 2'b00);
        do_req(0, 16'd500, '0, 2'b00);

        idle(4);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
